// File: rtl/fifo_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the FIFO write-side controller.
package fifo_ctrl_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Round-robin successor: the index after the winner becomes top priority.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted req at or above ptr, wrapping.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int   cand;
    logic found;

    always_comb begin
        // NOTE: every variable gets a default before the search so no path leaves one unassigned (no latch).
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PTR_W'(cand);
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with credit-style occupancy tracking for the shared FIFO.
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = fifo_ctrl_pkg::DATA_W,
    parameter int DEPTH   = fifo_ctrl_pkg::FIFO_DEPTH,
    parameter int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fifo_wrt,
    output logic [DATA_W-1:0]         fifo_data_in,
    input  logic                      rd_done,
    output logic [LVL_W-1:0]          level,
    output logic                      full,
    output logic                      empty,
    output logic [1:0]                state,
    output logic                      err_udf
);

    import fifo_ctrl_pkg::*;

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    state_t             state_q;
    state_t             state_d;
    logic               pick_en;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   pick_idx;
    logic               accept;
    logic               pop;
    logic               underflow;
    logic [LVL_W-1:0]   level_q;
    logic [LVL_W-1:0]   level_d;
    logic               full_q;
    logic               empty_q;
    logic               err_q;
    logic               wrt_q;
    logic [DATA_W-1:0]  data_q;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .enable (pick_en),
        .gnt    (gnt),
        .idx    (pick_idx),
        .valid  (accept)
    );

    // A pop only counts when there is something to pop; otherwise it is an underflow.
    assign pop       = rd_done && (level_q != '0);
    assign underflow = rd_done && (level_q == '0);

    always_comb begin
        level_d = level_q;
        if (accept && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!accept && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = (level_q == LVL_FULL) ? ST_FULL : ST_RUN;
                ST_RUN:  if (level_d == LVL_FULL) state_d = ST_FULL;
                ST_FULL: if (level_d < LVL_FULL) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Grants only in RUN with room left; en and rst also gate so a dropped en or a reset cycle issues nothing.
    always_comb begin
        pick_en = 1'b0;
        if (!rst && en && (state_q == ST_RUN) && (level_q < LVL_FULL)) begin
            pick_en = 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            ptr_q   <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
            wrt_q   <= 1'b0;
            // NOTE: the write-data register is reset too; it is a single visible register, not a storage array.
            data_q  <= '0;
        end else begin
            level_q <= level_d;
            full_q  <= (level_d == LVL_FULL);
            empty_q <= (level_d == '0);
            wrt_q   <= accept;
            if (underflow) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                ptr_q  <= PTR_W'(rr_next(int'(pick_idx), NUM_REQ));
                data_q <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
            end
        end
    end

    assign fifo_wrt     = wrt_q;
    assign fifo_data_in = data_q;
    assign level        = level_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign state        = state_q;
    assign err_udf      = err_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter and occupancy controller in front of the team's 8-entry, 32-bit FIFO. Up to NUM_REQ producers share the FIFO's single write port. The block grants one producer per cycle and drives the registered write strobe and data into the FIFO. It tracks FIFO occupancy with a credit counter, so the FIFO is never written while full and never under-counted.

## Interface
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 32, data width
- DEPTH, 8, FIFO entries
- LVL_W, $clog2(DEPTH)+1, occupancy width
- clk1  in  1  clock; all logic on posedge clk1
- rst  in  1  reset, synchronous, active-high
- en  in  1  arbitration enable
- req  in  NUM_REQ  per-producer valid; producer holds req and data stable until granted
- req_data  in  NUM_REQ*DATA_W  producer data, producer i at [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot accept, combinational; transfer occurs when req[i] & gnt[i]
- fifo_wrt  out  1  registered write strobe to the FIFO
- fifo_data_in  out  DATA_W  registered write data to the FIFO
- rd_done  in  1  one-cycle pulse per entry popped from the FIFO, already in the clk1 domain
- level  out  LVL_W  accepted-but-not-popped entry count
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- state  out  2  FSM state
- err_udf  out  1  sticky: rd_done seen while level == 0

## Operation
- FSM states: IDLE=0, RUN=1, FULL=2.
  - IDLE→RUN when en=1.
  - RUN→FULL when level_next == DEPTH.
  - FULL→RUN when level_next < DEPTH.
  - Any state→IDLE when en=0. From IDLE with en=1, go to FULL if level == DEPTH.
- Grant is allowed only in RUN, and only when level < DEPTH. No grant when full, even if rd_done is high that cycle.
- Round-robin: pointer ptr points at the highest-priority index. Search from ptr upward, wrapping modulo NUM_REQ. The first req found gets gnt.
- On an accept, ptr ← (granted index + 1) mod NUM_REQ. With no accept, ptr holds.
- On accept, next cycle: fifo_wrt=1 and fifo_data_in = granted producer's data. Otherwise fifo_wrt=0 and fifo_data_in holds its previous value.
- level_next = level + accept − (rd_done & level≠0). Simultaneous accept and rd_done leaves level unchanged.
- When rd_done arrives with level == 0: level stays 0 and err_udf is set. err_udf clears only on rst.
- level includes the entry sitting in the output register, i.e. an entry counts from the accept cycle.
- Dropping en mid-stream: a write already registered still issues next cycle. No new grants are made.

## Timing
- Reset values: gnt=0 (state IDLE), fifo_wrt=0, fifo_data_in=0, level=0, full=0, empty=1, state=IDLE, err_udf=0, ptr=0.
- gnt is combinational from req, ptr, state and level. There is no gnt in the cycle rst is high.
- Latency from accept cycle t to fifo_wrt=1 is one cycle (t+1).
- Throughput is one write per cycle while not full.
- level, full and empty are registered and update the cycle after the accept or rd_done edge.
- rst asserted mid-operation has effect on the next edge:
  - any pending registered write is dropped (fifo_wrt=0);
  - level and ptr are cleared.
  - The FIFO is reset by the same rst, so counts stay consistent.

## Structure
- Package fifo_ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_FULL;
  - default FIFO_DEPTH=8 and DATA_W=32.
- Sub-module rr_pick: a combinational round-robin selector.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot gnt and binary index.
  - The top level holds the FSM, the ptr register, the level counter and the output registers.

## Test plan
- Reset then en=1, req=4'b1111 held: accepts cycle 0,1,2,3 in order; fifo_data_in follows producer 0,1,2,3 one cycle later.
- Fill: 8 accepts with no rd_done → level=8, full=1, state=FULL, gnt=0. One rd_done pulse → level=7, then exactly one further grant.
- At level=8, rd_done in the same cycle as a request → no grant that cycle; level=7; grant on the next cycle.
- Simultaneous accept and rd_done at level=3 → level stays 3; fifo_wrt=1 the next cycle.
- rd_done at level=0 → err_udf=1 and stays set; level stays 0. rst clears err_udf.
- rst asserted the cycle after an accept → fifo_wrt=0 at the next edge, level=0, ptr=0. Producer 0 then wins a 4'b1111 request.
